rv_instr_encoder_loader: RTL

- Encodes instructions from field form (class, funct3, funct7[5], rd, rs1, rs2, signed immediate) into 32-bit RV32I words.
- Writes the words into the instruction-memory write port at consecutive word addresses.
- Sits between the test/boot host and instruction memory, ahead of the single-cycle core.
- Covers the same instruction classes the core's control decoder accepts: LW, SW, R-type, BEQ-class branch, I-type ALU, JAL, JALR.

---
 rtl/rv_instr_encoder_loader_if.sv | 30 +++
 rtl/rv_instr_encoder_loader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rv_instr_encoder_loader_if.sv
// rtl/rv_instr_encoder_loader_if.sv - field-input handshake and imem write port bundle
interface rv_instr_encoder_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic [2:0]        in_funct3;
  logic              in_funct7b5;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  // Host side: supplies instruction fields, observes the imem write port.
  modport master (
    output in_valid, in_kind, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_kind, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/rv_instr_encoder_loader.sv
// rtl/rv_instr_encoder_loader.sv - RV32I field-to-word encoder that loads instruction memory
module rv_instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  rv_instr_encoder_loader_if.slave  bus,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [ADDR_W:0]           count
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_ENC,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  logic              in_ready_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [2:0]        f_kind;
  logic [2:0]        f_f3;
  logic              f_f7b5;
  logic [4:0]        f_rd;
  logic [4:0]        f_rs1;
  logic [4:0]        f_rs2;
  logic [31:0]       f_imm;
  logic              f_last;

  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              imm_i_ok;
  logic              imm_b_ok;
  logic              imm_j_ok;

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

  // Encode the captured fields and judge whether the immediate fits its format.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b0;
    imm_i_ok  = (&f_imm[31:11]) | ~(|f_imm[31:11]);
    imm_b_ok  = ((&f_imm[31:12]) | ~(|f_imm[31:12])) & ~f_imm[0];
    imm_j_ok  = ((&f_imm[31:20]) | ~(|f_imm[31:20])) & ~f_imm[0];
    case (f_kind)
      3'd0: begin
        enc_word  = {f_imm[11:0], f_rs1, f_f3, f_rd, 7'b0000011};
        enc_legal = imm_i_ok;
      end
      3'd1: begin
        enc_word  = {f_imm[11:5], f_rs2, f_rs1, f_f3, f_imm[4:0], 7'b0100011};
        enc_legal = imm_i_ok;
      end
      3'd2: begin
        enc_word  = {1'b0, f_f7b5, 5'b00000, f_rs2, f_rs1, f_f3, f_rd, 7'b0110011};
        enc_legal = 1'b1;
      end
      3'd3: begin
        enc_word  = {f_imm[12], f_imm[10:5], f_rs2, f_rs1, f_f3, f_imm[4:1], f_imm[11], 7'b1100011};
        enc_legal = imm_b_ok;
      end
      3'd4: begin
        // Shifts carry a 5-bit shamt plus the arithmetic-select bit 30.
        if (f_f3 == 3'b001 || f_f3 == 3'b101) begin
          enc_word  = {1'b0, f_f7b5, 5'b00000, f_imm[4:0], f_rs1, f_f3, f_rd, 7'b0010011};
          enc_legal = ~(|f_imm[31:5]);
        end else begin
          enc_word  = {f_imm[11:0], f_rs1, f_f3, f_rd, 7'b0010011};
          enc_legal = imm_i_ok;
        end
      end
      3'd5: begin
        enc_word  = {f_imm[20], f_imm[10:1], f_imm[11], f_imm[19:12], f_rd, 7'b1101111};
        enc_legal = imm_j_ok;
      end
      3'd6: begin
        enc_word  = {f_imm[11:0], f_rs1, 3'b000, f_rd, 7'b1100111};
        enc_legal = imm_i_ok;
      end
      default: begin
        enc_word  = '0;
        enc_legal = 1'b0;
      end
    endcase
  end

  // Session FSM: accept fields, encode, write one word, repeat until last or error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready_q <= 1'b0;
      imem_we_q  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      addr_q     <= BASE;
      wdata_q    <= '0;
      count      <= '0;
      f_kind     <= '0;
      f_f3       <= '0;
      f_f7b5     <= 1'b0;
      f_rd       <= '0;
      f_rs1      <= '0;
      f_rs2      <= '0;
      f_imm      <= '0;
      f_last     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ERR: begin
          if (start) begin
            state      <= S_RUN;
            addr_q     <= BASE;
            count      <= '0;
            err        <= 1'b0;
            in_ready_q <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_RUN: begin
          if (bus.in_valid) begin
            f_kind     <= bus.in_kind;
            f_f3       <= bus.in_funct3;
            f_f7b5     <= bus.in_funct7b5;
            f_rd       <= bus.in_rd;
            f_rs1      <= bus.in_rs1;
            f_rs2      <= bus.in_rs2;
            f_imm      <= bus.in_imm;
            f_last     <= bus.in_last;
            in_ready_q <= 1'b0;
            state      <= S_ENC;
          end
        end
        S_ENC: begin
          if (enc_legal) begin
            wdata_q   <= enc_word;
            imem_we_q <= 1'b1;
            state     <= S_WRITE;
          end else begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_ERR;
          end
        end
        S_WRITE: begin
          imem_we_q <= 1'b0;
          count     <= count + (ADDR_W+1)'(1);
          // Address only advances while there is room, so it can never wrap.
          if (addr_q != LAST_ADDR) begin
            addr_q <= addr_q + ADDR_W'(1);
          end
          if (f_last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else if (addr_q == LAST_ADDR) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_ERR;
          end else begin
            in_ready_q <= 1'b1;
            state      <= S_RUN;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
